// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the two-port SPRAM arbiter.
package spram_arb_pkg;

    localparam int DATA_W     = 16;
    localparam int MASK_W     = 4;
    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } port_id_t;

    // One entry of the read-response pipeline: who gets the data, if anyone.
    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_tag_t;

endpackage

// File: rtl/spram_arb_grant.sv
// Grant decision for two requesters: round-robin or p0-priority with a starvation guard.
// Combinational grant, state updates on each accept; grants only ports whose request is high.
module spram_arb_grant
    import spram_arb_pkg::*;
#(
    parameter int MODE     = MODE_RR,
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    port_id_t          last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        hold_d = hold_q;

        if (MODE == MODE_RR) begin
            if (req_i == 2'b11) begin
                gnt_o = (last_q == P1) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
        end else begin
            if (req_i == 2'b11) begin
                gnt_o = (hold_q >= HOLD_MAX) ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
            // Counts p0 wins only while p1 is actually waiting.
            if (!req_i[1] || gnt_o[1]) begin
                hold_d = '0;
            end else if (gnt_o[0]) begin
                hold_d = hold_q + 1'b1;
            end
        end

        if (gnt_o[0]) begin
            last_d = P0;
        end else if (gnt_o[1]) begin
            last_d = P1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= P1;
            hold_q <= '0;
        end else begin
            last_q <= last_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Two-master sequencer for one SPRAM bank; registers the winning command and routes read data back.
// Command reaches the SPRAM one cycle after accept, read data returns two cycles after accept.
// Ready is granted to at most one valid port per cycle; a dropped valid leaves no trace.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int MODE     = MODE_RR,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_mask,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_mask,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_cs,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_maskwren,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] req;
    logic [1:0] gnt;

    // Requests are masked during reset so no ready can escape while state is held.
    assign req = {p1_valid, p0_valid} & {2{~reset}};

    spram_arb_grant #(
        .MODE     (MODE),
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign p0_ready = gnt[0];
    assign p1_ready = gnt[1];

    logic              accept;
    port_id_t          sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_mask;

    assign accept    = |gnt;
    assign sel       = gnt[1] ? P1 : P0;
    assign sel_we    = gnt[1] ? p1_we    : p0_we;
    assign sel_addr  = gnt[1] ? p1_addr  : p0_addr;
    assign sel_wdata = gnt[1] ? p1_wdata : p0_wdata;
    assign sel_mask  = gnt[1] ? p1_mask  : p0_mask;

    logic              cs_q,    cs_d;
    logic              wren_q,  wren_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q,  mask_d;
    rd_tag_t           tag1_q,  tag1_d;
    rd_tag_t           tag2_q;

    always_comb begin
        cs_d        = accept;
        wren_d      = accept & sel_we;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = '0;
        tag1_d      = '0;
        if (accept) begin
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            // Reads leave the nibble mask quiet so the bank sees no write intent.
            if (sel_we) begin
                mask_d = sel_mask;
            end
            tag1_d.valid = ~sel_we;
            tag1_d.port  = sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q    <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
        end else begin
            cs_q    <= cs_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag1_q;
        end
    end

    assign mem_cs       = cs_q;
    assign mem_wren     = wren_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_maskwren = mask_q;

    // The tag in stage 2 lines up with the SPRAM's registered output for that read.
    assign p0_rvalid = tag2_q.valid & (tag2_q.port == P0);
    assign p1_rvalid = tag2_q.valid & (tag2_q.port == P1);
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: instance 0 round-robin, instance 1 fixed priority, each with its own SPRAM model.
module tb_spram_arbiter;

    localparam int AW = 14;
    localparam int MH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          clr_mem;
    logic          p0_valid, p0_we, p1_valid, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [15:0]   p0_wdata, p1_wdata;
    logic [3:0]    p0_mask, p1_mask;

    logic          r0 [2];
    logic          r1 [2];
    logic          v0 [2];
    logic          v1 [2];
    logic [15:0]   d0 [2];
    logic [15:0]   d1 [2];
    logic          cs [2];
    logic          wr [2];
    logic [AW-1:0] ma [2];
    logic [15:0]   mw [2];
    logic [3:0]    mk [2];
    logic [15:0]   mr [2];

    logic [15:0]   mem [2][16384];

    int checks = 0;
    int errors = 0;

    spram_arbiter #(.ADDR_W(AW), .MODE(0), .MAX_HOLD(MH)) dut_rr (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(r0[0]), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_mask(p0_mask), .p0_rvalid(v0[0]), .p0_rdata(d0[0]),
        .p1_valid(p1_valid), .p1_ready(r1[0]), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_mask(p1_mask), .p1_rvalid(v1[0]), .p1_rdata(d1[0]),
        .mem_cs(cs[0]), .mem_wren(wr[0]), .mem_addr(ma[0]), .mem_wdata(mw[0]),
        .mem_maskwren(mk[0]), .mem_rdata(mr[0])
    );

    spram_arbiter #(.ADDR_W(AW), .MODE(1), .MAX_HOLD(MH)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(r0[1]), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_mask(p0_mask), .p0_rvalid(v0[1]), .p0_rdata(d0[1]),
        .p1_valid(p1_valid), .p1_ready(r1[1]), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_mask(p1_mask), .p1_rvalid(v1[1]), .p1_rdata(d1[1]),
        .mem_cs(cs[1]), .mem_wren(wr[1]), .mem_addr(ma[1]), .mem_wdata(mw[1]),
        .mem_maskwren(mk[1]), .mem_rdata(mr[1])
    );

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [3:0] m);
        logic [15:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[4*i +: 4] = wd[4*i +: 4];
        return r;
    endfunction

    // Behavioural SPRAM: masked write, registered read one cycle after cs.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (clr_mem) begin
                for (int i = 0; i < 16; i++) mem[m][i] <= '0;
            end else if (cs[m]) begin
                if (wr[m]) mem[m][ma[m]] <= merge(mem[m][ma[m]], mw[m], mk[m]);
                else       mr[m] <= mem[m][ma[m]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0; p0_mask = '0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_mask = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        repeat (2) tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        p0_valid = 1; p1_valid = 1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({r0[m], r1[m], v0[m], v1[m], cs[m], wr[m]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_ctrl inst%0d: got %b expected 000000", m,
                         {r0[m], r1[m], v0[m], v1[m], cs[m], wr[m]});
            end
            checks++;
            if ({d0[m], d1[m], ma[m], mw[m], mk[m]} !== '0) begin
                errors++;
                $display("FAIL reset_data inst%0d: got %h expected 0", m,
                         {d0[m], d1[m], ma[m], mw[m], mk[m]});
            end
        end
        tick();
        reset = 0;
        idle();
        tick();
    endtask

    task automatic test_write_read();
        p0_valid = 1; p0_we = 1; p0_addr = 14'h0010; p0_wdata = 16'hBEEF; p0_mask = 4'hF;
        @(negedge clk);
        checks++;
        if (r0[0] !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", r0[0]); end
        tick();
        p0_we = 0;
        @(negedge clk);
        checks++;
        if (r0[0] !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b expected 1", r0[0]); end
        checks++;
        if ({cs[0], wr[0], ma[0], mw[0], mk[0]} !== {1'b1, 1'b1, 14'h0010, 16'hBEEF, 4'hF}) begin
            errors++;
            $display("FAIL wr_cmd: got cs%b we%b a%h d%h m%h expected cs1 we1 a0010 dbeef mf",
                     cs[0], wr[0], ma[0], mw[0], mk[0]);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({cs[0], wr[0], v0[0]} !== 3'b100) begin
            errors++;
            $display("FAIL rd_cmd: got cs/we/rvalid %b expected 100", {cs[0], wr[0], v0[0]});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({v0[0], v1[0], d0[0]} !== {1'b1, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL rd_resp: got v0=%b v1=%b d=%h expected 1 0 beef", v0[0], v1[0], d0[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({v0[0], cs[0], mk[0], ma[0]} !== {1'b0, 1'b0, 4'h0, 14'h0010}) begin
            errors++;
            $display("FAIL rd_after: got v0=%b cs=%b m=%h a=%h expected 0 0 0 0010",
                     v0[0], cs[0], mk[0], ma[0]);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int n0, n1, ncs;
        n0 = 0; n1 = 0; ncs = 0;
        do_reset();
        p0_valid = 1; p0_addr = 14'h0001;
        p1_valid = 1; p1_addr = 14'h0002;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) idle();
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if ({r1[0], r0[0]} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL rr_grant cycle%0d: got %b expected %b", c, {r1[0], r0[0]},
                             (c % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            n0 += int'(v0[0]); n1 += int'(v1[0]); ncs += int'(cs[0]);
            tick();
        end
        checks++;
        if (n0 != 4 || n1 != 4 || ncs != 8) begin
            errors++;
            $display("FAIL rr_counts: got rv0=%0d rv1=%0d cs=%0d expected 4 4 8", n0, n1, ncs);
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp;
        do_reset();
        p0_valid = 1; p1_valid = 1;
        for (int c = 0; c < 10; c++) begin
            exp = (c % (MH + 1) == MH) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({r1[1], r0[1]} !== exp) begin
                errors++;
                $display("FAIL fp_grant cycle%0d: got %b expected %b", c, {r1[1], r0[1]}, exp);
            end
            tick();
        end
        idle();
        repeat (3) tick();
    endtask

    task automatic test_mask();
        p1_valid = 1; p1_we = 1; p1_addr = 14'h0020; p1_wdata = 16'h1234; p1_mask = 4'hF;
        tick();
        p1_wdata = 16'hABCD; p1_mask = 4'b0101;
        tick();
        p1_we = 0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (r1[m] !== 1'b1) begin errors++; $display("FAIL mask_rd_ready inst%0d: got %b expected 1", m, r1[m]); end
        end
        tick();
        idle();
        tick();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({v1[m], v0[m], d1[m]} !== {1'b1, 1'b0, 16'h1B3D}) begin
                errors++;
                $display("FAIL mask_data inst%0d: got v1=%b v0=%b d=%h expected 1 0 1b3d",
                         m, v1[m], v0[m], d1[m]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        p1_valid = 1; p1_addr = 14'h0020;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (r1[m] !== 1'b1) begin errors++; $display("FAIL mid_accept inst%0d: got %b expected 1", m, r1[m]); end
        end
        tick();
        idle();
        reset = 1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({v0[m], v1[m], cs[m], wr[m], mk[m], ma[m], d1[m]} !== '0) begin
                errors++;
                $display("FAIL mid_reset_outputs inst%0d: got %h expected 0", m,
                         {v0[m], v1[m], cs[m], wr[m], mk[m], ma[m], d1[m]});
            end
        end
        tick();
        tick();
        reset = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin p0_valid = 1; p1_valid = 1; end
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (v1[m] !== 1'b0) begin errors++; $display("FAIL mid_no_rvalid inst%0d cycle%0d: got %b expected 0", m, c, v1[m]); end
                if (c == 3) begin
                    checks++;
                    if ({r1[m], r0[m]} !== 2'b01) begin
                        errors++;
                        $display("FAIL mid_first_contest inst%0d: got %b expected 01", m, {r1[m], r0[m]});
                    end
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        logic [15:0] mm [2][16];
        bit          pend_v [2][4];
        bit          pend_p [2][4];
        logic [15:0] pend_d [2][4];
        int          last_g [2];
        int          streak [2];
        bit          exp_cs [2];
        int          g, slot;
        bit          we;
        logic [3:0]  a;

        idle();
        reset = 1; clr_mem = 1;
        tick();
        clr_mem = 0;
        tick();
        reset = 0;
        for (int m = 0; m < 2; m++) begin
            last_g[m] = 1; streak[m] = 0; exp_cs[m] = 0;
            for (int i = 0; i < 16; i++) mm[m][i] = '0;
            for (int k = 0; k < 4; k++) begin pend_v[m][k] = 0; pend_p[m][k] = 0; pend_d[m][k] = '0; end
        end

        for (int c = 0; c < 10000; c++) begin
            p0_valid = ($urandom_range(0, 99) < 60); p0_we = 1'($urandom_range(0, 1));
            p0_addr = AW'($urandom_range(0, 15)); p0_wdata = 16'($urandom); p0_mask = 4'($urandom);
            p1_valid = ($urandom_range(0, 99) < 60); p1_we = 1'($urandom_range(0, 1));
            p1_addr = AW'($urandom_range(0, 15)); p1_wdata = 16'($urandom); p1_mask = 4'($urandom);
            @(negedge clk);
            slot = c % 4;
            for (int m = 0; m < 2; m++) begin
                if (p0_valid && p1_valid) begin
                    if (m == 0) g = (last_g[m] == 0) ? 2 : 1;
                    else        g = (streak[m] >= MH) ? 2 : 1;
                end else if (p0_valid) g = 1;
                else if (p1_valid)     g = 2;
                else                   g = 0;

                checks++;
                if (r0[m] && r1[m]) begin errors++; $display("FAIL rnd_both_ready inst%0d cycle%0d: got 11 expected at most one", m, c); end
                checks++;
                if ({r1[m], r0[m]} !== {g == 2, g == 1}) begin
                    errors++;
                    $display("FAIL rnd_grant inst%0d cycle%0d: got %b expected %b", m, c,
                             {r1[m], r0[m]}, {g == 2, g == 1});
                end
                checks++;
                if ({v1[m], v0[m]} !== {pend_v[m][slot] && pend_p[m][slot], pend_v[m][slot] && !pend_p[m][slot]}) begin
                    errors++;
                    $display("FAIL rnd_rvalid inst%0d cycle%0d: got %b expected %b", m, c, {v1[m], v0[m]},
                             {pend_v[m][slot] && pend_p[m][slot], pend_v[m][slot] && !pend_p[m][slot]});
                end
                if (pend_v[m][slot]) begin
                    checks++;
                    if ((pend_p[m][slot] ? d1[m] : d0[m]) !== pend_d[m][slot]) begin
                        errors++;
                        $display("FAIL rnd_rdata inst%0d cycle%0d: got %h expected %h", m, c,
                                 pend_p[m][slot] ? d1[m] : d0[m], pend_d[m][slot]);
                    end
                end
                checks++;
                if (cs[m] !== exp_cs[m]) begin
                    errors++;
                    $display("FAIL rnd_cs inst%0d cycle%0d: got %b expected %b", m, c, cs[m], exp_cs[m]);
                end

                pend_v[m][slot] = 0;
                exp_cs[m] = (g != 0);
                if (g != 0) begin
                    we = (g == 2) ? p1_we : p0_we;
                    a  = (g == 2) ? p1_addr[3:0] : p0_addr[3:0];
                    if (we) begin
                        mm[m][a] = (g == 2) ? merge(mm[m][a], p1_wdata, p1_mask)
                                            : merge(mm[m][a], p0_wdata, p0_mask);
                    end else begin
                        pend_v[m][(c + 2) % 4] = 1;
                        pend_p[m][(c + 2) % 4] = (g == 2);
                        pend_d[m][(c + 2) % 4] = mm[m][a];
                    end
                    last_g[m] = g - 1;
                end
                if (!p1_valid || g == 2) streak[m] = 0;
                else if (g == 1)         streak[m]++;
            end
            tick();
        end
        idle();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1;
        clr_mem = 0;
        idle();
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_priority();
        test_mask();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
